imem_responder: RTL

Instruction-memory responder: the memory end of the core's fetch interface. It serves the core's PC as the address and returns the 32-bit instruction word.
Accepts fetch requests over a valid/ready channel, reads a word-addressed synchronous instruction RAM, and returns {pc, inst, err} over a valid/ready response channel buffered by a small FIFO.
A load port lets the simulation loader or testbench preload or patch the program image.
Sits between the fetch stage and the program image; replaces the testbench driving the instruction directly.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_responder_if.sv | 21 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/imem_responder.sv | 110 +++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [63:0] RESET_VECTOR = 64'h8000_0000;
  localparam logic [31:0] ERR_INST     = 32'h0000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } imem_resp_t;

  // Full-width compare against base + 4*depth so the upper bound never wraps.
  function automatic logic imem_addr_ok(input logic [63:0] pc,
                                        input logic [63:0] base,
                                        input int unsigned depth);
    logic [64:0] limit;
    limit = {1'b0, base} + {31'b0, depth, 2'b00};
    return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < limit);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / response channel between the core and the instruction memory.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_pc;
  logic [31:0] resp_inst;
  logic        resp_err;

  modport master (
    output req_valid, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_pc, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_pc, resp_ready,
    output req_ready, resp_valid, resp_pc, resp_inst, resp_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with arbitrary (non power-of-two) depth.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: synchronous RAM read stage feeding a response FIFO,
// with a load port for preloading or patching the program image.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter logic [63:0] BASE       = RESET_VECTOR,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_responder_if.slave          bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $bits(imem_resp_t);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  logic        s1_valid_q, s1_valid_d;
  logic [63:0] s1_pc_q, s1_pc_d;
  logic        s1_err_q, s1_err_d;

  logic          accept;
  logic [AW-1:0] rd_idx;
  logic [CW:0]   credits_used;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_pop;
  imem_resp_t    push_entry, head;
  logic [RW-1:0] head_raw;

  // Credits come only from registered state, so req_ready never depends on resp_ready.
  always_comb begin
    credits_used  = {1'b0, fifo_count} + (CW+1)'(s1_valid_q);
    bus.req_ready = rst_n && (credits_used < (CW+1)'(FIFO_DEPTH));
    accept        = bus.req_valid && bus.req_ready;
    rd_idx        = bus.req_pc[AW+1:2] - BASE[AW+1:2];
    s1_valid_d    = accept;
    s1_pc_d       = s1_pc_q;
    s1_err_d      = s1_err_q;
    if (accept) begin
      s1_pc_d  = bus.req_pc;
      s1_err_d = !imem_addr_ok(bus.req_pc, BASE, DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
      s1_err_q   <= s1_err_d;
    end
  end

  // Loads are honoured even in reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
    if (accept) begin
      rd_data_q <= mem[rd_idx];
    end
  end

  always_comb begin
    push_entry.pc   = s1_pc_q;
    push_entry.err  = s1_err_q;
    push_entry.inst = s1_err_q ? ERR_INST : rd_data_q;
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_valid_q),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_raw),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head = imem_resp_t'(head_raw);

  always_comb begin
    bus.resp_valid = !fifo_empty;
    fifo_pop       = !fifo_empty && bus.resp_ready;
    bus.resp_pc    = bus.resp_valid ? head.pc : '0;
    bus.resp_inst  = bus.resp_valid ? head.inst : '0;
    bus.resp_err   = bus.resp_valid ? head.err : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(s1_valid_q && fifo_full && !fifo_pop));
    end
  end

endmodule
